inta_sequencer: RTL and testbench
=================================

INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: irr  in  8  pending unmasked requests, bit n = IRn.
REQ-004 SHALL have ports: isr  in  8  current in-service bits from the ISR stage.
REQ-005 SHALL have ports: inta_n  in  1  CPU acknowledge, active-low, already synchronous to clk.
REQ-006 SHALL have ports: vector_base  in  5  ICW2 bits T7..T3.
REQ-007 SHALL have ports: int_out  out  1  interrupt request to CPU.
REQ-008 SHALL have ports: highest_priority_idx  out  3  latched IR index for the ISR stage.
REQ-009 SHALL have ports: ack1  out  1  active-low one-cycle strobe, first acknowledge.
REQ-010 SHALL have ports: ack2  out  1  active-low one-cycle strobe, second acknowledge.
REQ-011 SHALL have ports: data_out  out  8  vector byte; data_oe  out  1  vector drive enable.

Function
REQ-012 SHALL register inta_n each cycle; falling edge = previous 1 and current 0, rising edge = previous 0 and current 1.
REQ-013 SHALL resolve combinationally: winner = highest-priority set irr bit whose priority is strictly above every set isr bit; valid when one exists.
REQ-014 SHALL use fixed priority IR0 highest, IR7 lowest, unless REQ-027 applies.
REQ-015 SHALL implement FSM IDLE, WAIT1, PULSE1, WAIT2, PULSE2.
REQ-016 IDLE: winner valid -> WAIT1, int_out=1 next cycle; a falling edge in IDLE SHALL be ignored.
REQ-017 WAIT1: int_out held 1 even if request withdrawn; falling edge -> PULSE1, latch winner into highest_priority_idx, ack1=0 for exactly that one cycle, int_out=0.
REQ-018 Spurious: no winner valid at the WAIT1 falling edge -> latch index 7, ack1 SHALL stay 1, spurious flag set.
REQ-019 PULSE1: rising edge -> WAIT2; a second falling edge SHALL NOT be recognised before that rising edge.
REQ-020 WAIT2: falling edge -> PULSE2, ack2=0 for exactly one cycle, also for spurious.
REQ-021 PULSE2: data_out={vector_base, highest_priority_idx}, data_oe=1 while inta_n low; rising edge -> IDLE, data_oe=0 the same cycle.
REQ-022 data_out SHALL be 8'h00 whenever data_oe=0.
REQ-023 highest_priority_idx SHALL hold its latched value until the next PULSE1 entry.
REQ-024 irr/isr changes after the WAIT1 falling edge SHALL NOT alter the latched index or vector.

Reset
REQ-025 reset=1 SHALL force IDLE on the next edge from any state, including mid-sequence: int_out=0, ack1=1, ack2=1, data_oe=0, data_out=0, highest_priority_idx=0, inta_n history=1, spurious flag=0, lowest-priority pointer=7.
REQ-026 reset SHALL dominate any simultaneous inta_n edge or request.

Configuration
REQ-027 INTA_ROTATE_EN defined: rotating priority; on ack2 of a non-spurious cycle, lowest-priority pointer := latched index, priority order (pointer+1) mod 8 highest down to pointer.
REQ-028 INTA_ROTATE_EN undefined: pointer fixed at 7, no rotation logic; behaviour identical to fixed priority.

Verification
REQ-029 irr=8'h24, isr=0, two inta_n pulses -> int_out=1, ack1 pulse, idx=2, ack2 pulse, data_out=8'h42 with vector_base=5'h08.
REQ-030 irr=8'h10, isr=8'h04 -> int_out stays 0; then isr=0 -> int_out=1, sequence yields idx=4.
REQ-031 irr=8'h01 raised then cleared before first falling edge -> ack1 stays 1, ack2 pulses, data_out={vector_base,3'd7}.
REQ-032 reset asserted in WAIT2 -> next cycle IDLE, all outputs at reset values, following inta_n pulses ignored.
REQ-033 INTA_ROTATE_EN: service IR3, then irr=8'h09 -> IR3 lowest, IR4..IR7,IR0 higher, winner idx=0 with data_out bits [2:0]=3'd0; without macro same stimulus also gives idx=0, then irr=8'h18 gives idx=3 without macro, idx=4 with macro after IR3 serviced.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer: 8259-style interrupt acknowledge sequencer.
// Raises int_out when an unmasked request outranks every in-service level,
// then tracks the two-pulse INTA handshake from the CPU: the first pulse
// latches the winning IR index (ack1 strobe), the second presents the vector
// byte {vector_base, index} on data_out (ack2 strobe, data_oe).
// A request that disappears before the first pulse gives a spurious cycle
// that reports IR7 without ack1.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   irr[7:0], isr[7:0]    - pending requests, in-service bits
//   inta_n                - CPU acknowledge, active-low, synchronous
//   vector_base[4:0]      - vector bits T7..T3
//   int_out               - interrupt request to the CPU
//   highest_priority_idx  - latched IR index
//   ack1, ack2            - active-low one-cycle acknowledge strobes
//   data_out, data_oe     - vector byte and its drive enable
// Build option: define INTA_ROTATE_EN for rotating priority (the serviced
// level becomes the lowest priority after each non-spurious ack2).
module inta_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] irr,
   input  logic [7:0] isr,
   input  logic       inta_n,
   input  logic [4:0] vector_base,
   output logic       int_out,
   output logic [2:0] highest_priority_idx,
   output logic       ack1,
   output logic       ack2,
   output logic [7:0] data_out,
   output logic       data_oe
);

   typedef enum logic [2:0] {StIdle, StWait1, StPulse1, StWait2, StPulse2} state_e;

   state_e     state_q;
   logic       inta_q;
   logic       int_out_q;
   logic [2:0] idx_q;
   logic       ack1_q;
   logic       ack2_q;
   logic [7:0] data_q;
   logic       data_oe_q;
   logic       spurious_q;
   logic [2:0] lowest;

`ifdef INTA_ROTATE_EN
   logic [2:0] lowest_q;
   assign lowest = lowest_q;
`else
   assign lowest = 3'd7;
`endif

   logic inta_fall;
   logic inta_rise;
   assign inta_fall = inta_q & ~inta_n;
   assign inta_rise = ~inta_q & inta_n;

   // Walk levels from highest priority (lowest+1) downward; the first set isr
   // bit blocks everything at or below it.
   logic       win_valid;
   logic [2:0] win_idx;
   logic       blocked;
   logic [2:0] pos;

   always_comb begin
      win_valid = 1'b0;
      win_idx   = 3'd0;
      blocked   = 1'b0;
      pos       = 3'd0;
      for (int k = 0; k < 8; k++) begin
         pos = lowest + 3'(k + 1);
         if (!win_valid && !blocked) begin
            if (isr[pos]) begin
               blocked = 1'b1;
            end else if (irr[pos]) begin
               win_valid = 1'b1;
               win_idx   = pos;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         inta_q     <= 1'b1;
         int_out_q  <= 1'b0;
         idx_q      <= 3'd0;
         ack1_q     <= 1'b1;
         ack2_q     <= 1'b1;
         data_q     <= 8'h00;
         data_oe_q  <= 1'b0;
         spurious_q <= 1'b0;
`ifdef INTA_ROTATE_EN
         lowest_q   <= 3'd7;
`endif
      end else begin
         inta_q <= inta_n;
         // Strobes default high so each low lasts exactly one cycle.
         ack1_q <= 1'b1;
         ack2_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (win_valid) begin
                  state_q   <= StWait1;
                  int_out_q <= 1'b1;
               end
            end
            StWait1: begin
               if (inta_fall) begin
                  state_q    <= StPulse1;
                  int_out_q  <= 1'b0;
                  idx_q      <= win_valid ? win_idx : 3'd7;
                  ack1_q     <= ~win_valid;
                  spurious_q <= ~win_valid;
               end
            end
            StPulse1: begin
               if (inta_rise) begin
                  state_q <= StWait2;
               end
            end
            StWait2: begin
               if (inta_fall) begin
                  state_q   <= StPulse2;
                  ack2_q    <= 1'b0;
                  data_oe_q <= 1'b1;
                  // Spurious cycles always report IR7.
                  data_q    <= {vector_base, spurious_q ? 3'd7 : idx_q};
`ifdef INTA_ROTATE_EN
                  if (!spurious_q) begin
                     lowest_q <= idx_q;
                  end
`endif
               end
            end
            StPulse2: begin
               if (inta_rise) begin
                  state_q   <= StIdle;
                  data_oe_q <= 1'b0;
                  data_q    <= 8'h00;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign int_out              = int_out_q;
   assign highest_priority_idx = idx_q;
   assign ack1                 = ack1_q;
   assign ack2                 = ack2_q;
   assign data_out             = data_q;
   assign data_oe              = data_oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
module tb_inta_sequencer;

   logic       clk;
   logic       reset;
   logic [7:0] irr;
   logic [7:0] isr;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       int_out;
   logic [2:0] highest_priority_idx;
   logic       ack1;
   logic       ack2;
   logic [7:0] data_out;
   logic       data_oe;

   inta_sequencer dut (
      .clk                  (clk),
      .reset                (reset),
      .irr                  (irr),
      .isr                  (isr),
      .inta_n               (inta_n),
      .vector_base          (vector_base),
      .int_out              (int_out),
      .highest_priority_idx (highest_priority_idx),
      .ack1                 (ack1),
      .ack2                 (ack2),
      .data_out             (data_out),
      .data_oe              (data_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         ack1_seen;
      logic [2:0] idx;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

`ifdef INTA_ROTATE_EN
   localparam bit Rot = 1'b1;
`else
   localparam bit Rot = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation each time the vector is driven.
   bit seen_ack1 = 0;
   bit ack1_prev_low = 0;
   bit ack2_prev_low = 0;
   bit oe_prev = 0;

   always @(negedge clk) begin
      if (reset) begin
         seen_ack1 = 0;
      end else begin
         if (!ack1) begin
            seen_ack1 = 1;
            if (ack1_prev_low) chk("ack1_one_cycle", 1, 0);
         end
         if (!ack2 && ack2_prev_low) chk("ack2_one_cycle", 1, 0);
         if (!data_oe) chk("data_out_idle_zero", 32'(data_out), 0);
         if (data_oe && !oe_prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_vector", 32'(data_out), 32'hffff_ffff);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("vector_data", 32'(data_out), 32'(e.data));
               chk("latched_idx", 32'(highest_priority_idx), 32'(e.idx));
               chk("ack1_pulsed", 32'(seen_ack1), 32'(e.ack1_seen));
               chk("ack2_with_vector", 32'(ack2), 0);
            end
            seen_ack1 = 0;
         end
      end
      ack1_prev_low = !ack1;
      ack2_prev_low = !ack2;
      oe_prev       = data_oe;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One INTA pulse: 2 cycles low, 2 cycles high.
   task automatic inta_pulse();
      cycles(1);
      inta_n = 1'b0;
      cycles(2);
      inta_n = 1'b1;
      cycles(2);
   endtask

   task automatic service(input logic [7:0] irr_v, input logic [7:0] isr_v,
                          input logic [7:0] irr_after, input logic [7:0] isr_after,
                          input bit exp_ack1, input logic [2:0] exp_idx,
                          input string name);
      exp_t e;
      irr = irr_v;
      isr = isr_v;
      cycles(2);
      chk({name, "_int_out"}, 32'(int_out), 1);
      e.ack1_seen = exp_ack1;
      e.idx       = exp_idx;
      e.data      = {vector_base, exp_idx};
      sb.push_back(e);
      inta_pulse();
      chk({name, "_int_out_dropped"}, 32'(int_out), 0);
      irr = irr_after;
      isr = isr_after;
      inta_pulse();
      irr = 8'h00;
      isr = 8'h00;
      cycles(2);
      chk({name, "_oe_released"}, 32'(data_oe), 0);
      chk({name, "_idle_int_out"}, 32'(int_out), 0);
   endtask

   task automatic chk_reset_outputs(input string name);
      @(negedge clk);
      chk({name, "_int_out"}, 32'(int_out), 0);
      chk({name, "_ack1"}, 32'(ack1), 1);
      chk({name, "_ack2"}, 32'(ack2), 1);
      chk({name, "_data_oe"}, 32'(data_oe), 0);
      chk({name, "_data_out"}, 32'(data_out), 0);
      chk({name, "_idx"}, 32'(highest_priority_idx), 0);
   endtask

   initial begin
      reset       = 1'b1;
      irr         = 8'h00;
      isr         = 8'h00;
      inta_n      = 1'b1;
      vector_base = 5'h08;
      cycles(2);
      chk_reset_outputs("reset");
      reset = 1'b0;
      cycles(1);

      // Basic: IR2 beats IR5; late irr/isr changes must not disturb the vector.
      service(8'h24, 8'h00, 8'h01, 8'h01, 1'b1, 3'd2, "basic");

      // In-service IR2 blocks IR4 until cleared.
      irr = 8'h10;
      isr = 8'h04;
      cycles(3);
      chk("isr_blocks_int_out", 32'(int_out), 0);
      service(8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 3'd4, "unblocked");

      // Spurious: request withdrawn before the first acknowledge.
      irr = 8'h01;
      cycles(2);
      chk("spur_int_out", 32'(int_out), 1);
      irr = 8'h00;
      cycles(3);
      chk("spur_int_out_held", 32'(int_out), 1);
      begin
         exp_t e;
         e.ack1_seen = 1'b0;
         e.idx       = 3'd7;
         e.data      = 8'h47;
         sb.push_back(e);
      end
      inta_pulse();
      inta_pulse();
      cycles(2);
      chk("spur_oe_released", 32'(data_oe), 0);

      // Priority order, with and without rotation.
      vector_base = 5'h1a;
      service(8'h08, 8'h00, 8'h00, 8'h00, 1'b1, 3'd3, "rot_ir3");
      service(8'h09, 8'h00, 8'h00, 8'h00, 1'b1, 3'd0, "rot_09");
      service(8'h08, 8'h00, 8'h00, 8'h00, 1'b1, 3'd3, "rot_ir3_again");
      service(8'h18, 8'h00, 8'h00, 8'h00, 1'b1, Rot ? 3'd4 : 3'd3, "rot_18");

      // Reset in WAIT2: back to reset outputs; later INTA pulses ignored.
      irr = 8'h04;
      cycles(2);
      inta_pulse();
      irr = 8'h00;
      inta_n = 1'b0;
      reset  = 1'b1;
      cycles(1);
      chk_reset_outputs("mid_reset");
      reset  = 1'b0;
      inta_n = 1'b1;
      cycles(1);
      inta_pulse();
      inta_pulse();
      chk("post_reset_int_out", 32'(int_out), 0);
      chk("post_reset_oe", 32'(data_oe), 0);
      chk("post_reset_ack1", 32'(ack1), 1);

      // Pointer back at 7 after reset: IR3 beats IR4 in both builds.
      service(8'h18, 8'h00, 8'h00, 8'h00, 1'b1, 3'd3, "ptr_after_reset");

      cycles(2);
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
